stream_mux: RTL and testbench

STREAM_MUX -- requirements
Module: stream_mux

---
 rtl/stream_mux_pkg.sv | 18 +
 rtl/stream_mux_rr_arbiter.sv | 43 ++++
 rtl/stream_mux.sv | 116 +++++++++++
 tb/tb_stream_mux.sv | 131 +++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stream_mux_pkg
// Purpose : Shared mode encodings and default geometry for stream_mux.
// Rev     : 1.0  initial release
// ============================================================================
package stream_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    localparam int DEFAULT_N_CH = 4;
    localparam int DEFAULT_W    = 8;

endpackage
`default_nettype wire

// File: rtl/stream_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin grant search starting at ptr (cyclic).
// Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N_CH = DEFAULT_N_CH,
    parameter int SW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic [SW-1:0]   grant,
    output logic            grant_valid
);

    logic [2*N_CH-1:0] w_rot;
    logic [SW:0]       w_sum;

    // Rotating the doubled vector puts the request at ptr into bit 0.
    assign w_rot = {req, req} >> ptr;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        w_sum       = '0;
        // Descending scan: the lowest rotated offset is assigned last and wins.
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, ptr} + (SW+1)'(k);
                if (w_sum >= (SW+1)'(N_CH)) begin
                    w_sum = w_sum - (SW+1)'(N_CH);
                end
                grant       = w_sum[SW-1:0];
                grant_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_mux.sv
`default_nettype none
// ============================================================================
// Module  : stream_mux
// Purpose : N-channel valid/ready stream mux, fixed-select or round-robin,
//           with a single registered output stage.
// Rev     : 1.0  initial release
// ============================================================================
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int N_CH = DEFAULT_N_CH,
    parameter int W    = DEFAULT_W,
    parameter int SW   = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [SW-1:0]     sel,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    output logic [W-1:0]      out_data,
    output logic [SW-1:0]     out_ch,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_ch;
    logic          r_out_valid;
    logic [SW-1:0] r_ptr;

    logic          w_is_rr;
    logic          w_sel_in_range;
    logic          w_sel_req;
    logic          w_fix_valid;
    logic [SW-1:0] w_rr_grant;
    logic          w_rr_valid;
    logic [SW-1:0] w_grant;
    logic          w_grant_valid;
    logic          w_load;
    logic [W-1:0]  w_grant_data;
    logic [SW-1:0] w_ptr_next;

    assign w_is_rr        = (mode == MODE_RR);
    assign w_sel_in_range = ({1'b0, sel} < (SW+1)'(N_CH));

    // Compare-based lookup keeps sel wider than the channel index legal.
    always_comb begin
        w_sel_req = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel == SW'(i)) begin
                w_sel_req = in_valid[i];
            end
        end
    end

    assign w_fix_valid = w_sel_in_range && w_sel_req;

    rr_arbiter #(
        .N_CH (N_CH),
        .SW   (SW)
    ) u_rr_arbiter (
        .req         (in_valid),
        .ptr         (r_ptr),
        .grant       (w_rr_grant),
        .grant_valid (w_rr_valid)
    );

    assign w_grant       = w_is_rr ? w_rr_grant : sel;
    assign w_grant_valid = w_is_rr ? w_rr_valid : w_fix_valid;
    assign w_load        = !rst && (!r_out_valid || out_ready) && w_grant_valid;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ready
            assign in_ready[i] = w_load && (w_grant == SW'(i));
        end
    endgenerate

    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_grant == SW'(i)) begin
                w_grant_data = in_data[i*W +: W];
            end
        end
    end

    assign w_ptr_next = (w_grant == SW'(N_CH - 1)) ? '0 : w_grant + SW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else begin
            if (w_load) begin
                r_out_data  <= w_grant_data;
                r_out_ch    <= w_grant;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_load && w_is_rr) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux.sv
`default_nettype none
// ============================================================================
// Module  : tb_stream_mux
// Purpose : Directed table-driven bench for stream_mux (N_CH=4, W=8, SW=3).
// Rev     : 1.0  initial release
// ============================================================================
module tb_stream_mux;

    logic        clk;
    logic        rst;
    logic        mode;
    logic [2:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [2:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] c_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
    localparam logic [31:0] c_data2 = {8'h99, 8'h88, 8'h77, 8'h66};

    stream_mux #(
        .N_CH (4),
        .W    (8),
        .SW   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        mode;
        logic [2:0]  sel;
        logic [3:0]  valid;
        logic        ord;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [7:0]  exp_od;
        logic [2:0]  exp_och;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive at negedge, check combinational ready, then registered outputs after the edge.
    task automatic step(input string name, input logic r, input logic m, input logic [2:0] s,
                        input logic [3:0] v, input logic [31:0] d, input logic o,
                        input logic [3:0] e_rdy, input logic e_ov, input logic [7:0] e_od,
                        input logic [2:0] e_och);
        @(negedge clk);
        rst = r; mode = m; sel = s; in_valid = v; in_data = d; out_ready = o;
        #1;
        check({name, " in_ready"}, 32'(in_ready), 32'(e_rdy));
        @(posedge clk);
        #1;
        check({name, " out_valid"}, 32'(out_valid), 32'(e_ov));
        check({name, " out_data"}, 32'(out_data), 32'(e_od));
        check({name, " out_ch"}, 32'(out_ch), 32'(e_och));
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;

        //            rst  mode sel   valid    ord   rdy      ov    od     och
        vecs[0]  = '{1'b1,1'b0,3'd0,4'b1111,1'b1,4'b0000,1'b0,8'h00,3'd0};
        vecs[1]  = '{1'b1,1'b0,3'd0,4'b1111,1'b1,4'b0000,1'b0,8'h00,3'd0};
        vecs[2]  = '{1'b0,1'b0,3'd2,4'b0100,1'b1,4'b0100,1'b1,8'hA5,3'd2};
        vecs[3]  = '{1'b0,1'b0,3'd5,4'b1111,1'b1,4'b0000,1'b0,8'hA5,3'd2};
        vecs[4]  = '{1'b0,1'b0,3'd1,4'b0000,1'b1,4'b0000,1'b0,8'hA5,3'd2};
        vecs[5]  = '{1'b0,1'b1,3'd0,4'b1111,1'b1,4'b0001,1'b1,8'h11,3'd0};
        vecs[6]  = '{1'b0,1'b1,3'd0,4'b1111,1'b1,4'b0010,1'b1,8'h22,3'd1};
        vecs[7]  = '{1'b0,1'b1,3'd0,4'b1111,1'b1,4'b0100,1'b1,8'hA5,3'd2};
        vecs[8]  = '{1'b0,1'b1,3'd0,4'b1111,1'b1,4'b1000,1'b1,8'h44,3'd3};
        vecs[9]  = '{1'b0,1'b1,3'd0,4'b1111,1'b1,4'b0001,1'b1,8'h11,3'd0};
        vecs[10] = '{1'b0,1'b1,3'd0,4'b0100,1'b1,4'b0100,1'b1,8'hA5,3'd2};
        vecs[11] = '{1'b0,1'b1,3'd0,4'b0011,1'b1,4'b0001,1'b1,8'h11,3'd0};
        vecs[12] = '{1'b0,1'b1,3'd0,4'b0011,1'b1,4'b0010,1'b1,8'h22,3'd1};
        vecs[13] = '{1'b0,1'b1,3'd0,4'b0000,1'b1,4'b0000,1'b0,8'h22,3'd1};
        vecs[14] = '{1'b0,1'b0,3'd3,4'b1000,1'b0,4'b1000,1'b1,8'h44,3'd3};
        vecs[15] = '{1'b0,1'b1,3'd0,4'b1111,1'b0,4'b0000,1'b1,8'h44,3'd3};
        vecs[16] = '{1'b0,1'b1,3'd0,4'b1111,1'b1,4'b0100,1'b1,8'hA5,3'd2};

        for (int i = 0; i < 17; i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].mode, vecs[i].sel, vecs[i].valid,
                 c_data, vecs[i].ord, vecs[i].exp_rdy, vecs[i].exp_ov, vecs[i].exp_od,
                 vecs[i].exp_och);
        end

        // Backpressure: held word A5/ch2 must survive changing inputs; ptr is 3.
        step("bp0", 1'b0, 1'b1, 3'd0, 4'b1111, c_data2, 1'b0, 4'b0000, 1'b1, 8'hA5, 3'd2);
        step("bp1", 1'b0, 1'b0, 3'd1, 4'b0010, c_data2, 1'b0, 4'b0000, 1'b1, 8'hA5, 3'd2);
        step("bp2", 1'b0, 1'b1, 3'd0, 4'b0001, c_data,  1'b0, 4'b0000, 1'b1, 8'hA5, 3'd2);
        step("bp_release", 1'b0, 1'b1, 3'd0, 4'b1111, c_data, 1'b1, 4'b1000, 1'b1, 8'h44, 3'd3);

        // Reset mid-stream: move ptr to 1, stall, reset, then RR must restart at channel 0.
        step("rs_load", 1'b0, 1'b1, 3'd0, 4'b1111, c_data, 1'b1, 4'b0001, 1'b1, 8'h11, 3'd0);
        step("rs_hold", 1'b0, 1'b1, 3'd0, 4'b1111, c_data, 1'b0, 4'b0000, 1'b1, 8'h11, 3'd0);
        step("rs_rst",  1'b1, 1'b1, 3'd0, 4'b1111, c_data, 1'b0, 4'b0000, 1'b0, 8'h00, 3'd0);
        step("rs_after", 1'b0, 1'b1, 3'd0, 4'b1111, c_data, 1'b1, 4'b0001, 1'b1, 8'h11, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
